// File: rtl/cordic_dispatch_if.sv
// rtl/cordic_dispatch_if.sv - request/response stream and core job bundle for cordic_dispatch
interface cordic_dispatch_if #(
    parameter int FLOAT_DATA_WIDTH = 32
);
    logic                        in_valid;
    logic                        in_ready;
    logic [FLOAT_DATA_WIDTH-1:0] in_angle;
    logic                        out_valid;
    logic                        out_ready;
    logic [FLOAT_DATA_WIDTH-1:0] out_result;
    logic                        out_error;
    logic                        cordic_clk_en;
    logic [FLOAT_DATA_WIDTH-1:0] cordic_angle;
    logic                        cordic_done;
    logic [FLOAT_DATA_WIDTH-1:0] cordic_result;

    // dispatcher side
    modport slave (
        input  in_valid, in_angle, out_ready, cordic_done, cordic_result,
        output in_ready, out_valid, out_result, out_error, cordic_clk_en, cordic_angle
    );

    // producer / consumer / core side
    modport master (
        output in_valid, in_angle, out_ready, cordic_done, cordic_result,
        input  in_ready, out_valid, out_result, out_error, cordic_clk_en, cordic_angle
    );
endinterface

// File: rtl/cordic_dispatch.sv
// rtl/cordic_dispatch.sv - FIFO-buffered one-job-at-a-time front end for the CORDIC cosine core
module cordic_dispatch #(
    parameter int FLOAT_DATA_WIDTH = 32,
    parameter int FIFO_ADDR_WIDTH  = 2,
    parameter int TIMEOUT_CYCLES   = 64,
    parameter int TIMEOUT_WIDTH    = 7
) (
    input  logic              clk,
    input  logic              rst,
    cordic_dispatch_if.slave  bus,
    output logic              busy
);
    localparam int DEPTH = 2 ** FIFO_ADDR_WIDTH;
    localparam int CNT_W = FIFO_ADDR_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DRAIN} state_t;

    state_t                      state;
    state_t                      state_nxt;
    logic [FLOAT_DATA_WIDTH-1:0] mem [DEPTH];
    logic [FIFO_ADDR_WIDTH-1:0]  wr_ptr;
    logic [FIFO_ADDR_WIDTH-1:0]  rd_ptr;
    logic [CNT_W-1:0]            count;
    logic [TIMEOUT_WIDTH-1:0]    tmo_cnt;
    logic                        done_q;
    logic                        drain_wait;
    logic                        push;
    logic                        pop;
    logic                        done_rise;
    logic                        timeout_hit;

    assign bus.in_ready      = (count != CNT_W'(DEPTH));
    assign push              = bus.in_valid & bus.in_ready;
    // a new job only starts once the previous result has left, keeping order with one in flight
    assign pop               = (state == S_IDLE) & (count != '0) & ~bus.out_valid;
    // the core holds done for up to two cycles; only the rising edge ends a job
    assign done_rise         = bus.cordic_done & ~done_q;
    assign timeout_hit       = (tmo_cnt == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1));
    assign bus.cordic_clk_en = (state == S_ISSUE);
    assign busy              = (count != '0) | (state != S_IDLE) | bus.out_valid;

    // angle storage, written on push only
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_angle;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_ADDR_WIDTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_ADDR_WIDTH'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state: issue, wait for done or timeout, then let the core's done fall
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (pop) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT:  if (done_rise || timeout_hit) state_nxt = S_DRAIN;
            S_DRAIN: if (!bus.cordic_done || drain_wait) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // job datapath: held angle, timeout counter, result register and output handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.cordic_angle <= '0;
            bus.out_valid    <= 1'b0;
            bus.out_result   <= '0;
            bus.out_error    <= 1'b0;
            tmo_cnt          <= '0;
            done_q           <= 1'b0;
            drain_wait       <= 1'b0;
        end else begin
            done_q     <= bus.cordic_done;
            drain_wait <= (state == S_DRAIN);
            if (pop) begin
                bus.cordic_angle <= mem[rd_ptr];
            end
            if (state == S_ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == S_WAIT) begin
                tmo_cnt <= tmo_cnt + TIMEOUT_WIDTH'(1);
            end
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            // a done rise on the timeout cycle still delivers the real result
            if (state == S_WAIT) begin
                if (done_rise) begin
                    bus.out_result <= bus.cordic_result;
                    bus.out_error  <= 1'b0;
                    bus.out_valid  <= 1'b1;
                end else if (timeout_hit) begin
                    bus.out_result <= '0;
                    bus.out_error  <= 1'b1;
                    bus.out_valid  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_cordic_dispatch.sv
// tb/tb_cordic_dispatch.sv - directed self-checking bench for cordic_dispatch
module tb_cordic_dispatch;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic busy;

    cordic_dispatch_if #(.FLOAT_DATA_WIDTH(32)) bus ();

    cordic_dispatch dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // core model controls and observations
    int core_latency = 20;
    int core_hold    = 1;
    bit core_never   = 1'b0;
    int clk_en_count = 0;
    int angle_changes = 0;
    int overlap_err  = 0;

    function automatic logic [31:0] core_fn(input logic [31:0] a);
        return (a == 32'h3F060A92) ? 32'h3F5DB3D7 : (a ^ 32'h5A5A0000);
    endfunction

    // behavioural core: done rises core_latency cycles after clk_en, held core_hold cycles
    initial begin
        int lat;
        int hold_left;
        bit track;
        logic [31:0] core_angle;
        lat = 0;
        hold_left = 0;
        track = 1'b0;
        core_angle = '0;
        bus.cordic_done = 1'b0;
        bus.cordic_result = '0;
        forever begin
            @(negedge clk);
            if (!rst) track = 1'b0;
            if (hold_left > 0) begin
                hold_left--;
                if (hold_left == 0) bus.cordic_done = 1'b0;
            end
            if (bus.cordic_clk_en) begin
                if (lat > 0 || hold_left > 0) overlap_err++;
                clk_en_count++;
                core_angle = bus.cordic_angle;
                track = 1'b1;
                if (!core_never) lat = core_latency;
            end else if (lat > 0) begin
                lat--;
                if (lat == 0) begin
                    bus.cordic_done = 1'b1;
                    bus.cordic_result = core_fn(core_angle);
                    hold_left = core_hold;
                end
            end
            if (track && rst && bus.cordic_angle !== core_angle) angle_changes++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_one(input string tag, input logic [31:0] a);
        check({tag, "_in_ready"}, bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_angle = a;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic [31:0] exp_data, input logic exp_err);
        int n;
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, bus.out_valid, 1'b1);
        check({tag, "_result"}, bus.out_result, exp_data);
        check({tag, "_error"}, bus.out_error, exp_err);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] b2b_in  [5];
        logic [31:0] b2b_exp [5];
        int base;
        int n;
        int stall_err;

        b2b_in  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};
        b2b_exp = '{32'h65DA0000, 32'h1A5A0000, 32'h1A1A0000, 32'h1ADA0000, 32'h1AFA0000};
        bus.in_valid  = 1'b0;
        bus.in_angle  = '0;
        bus.out_ready = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_result", bus.out_result, 32'h0);
        check("rst_out_error", bus.out_error, 1'b0);
        check("rst_clk_en", bus.cordic_clk_en, 1'b0);
        check("rst_angle", bus.cordic_angle, 32'h0);
        check("rst_busy", busy, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // single job, pi/6
        base = clk_en_count;
        push_one("single", 32'h3F060A92);
        get_result("single", 32'h3F5DB3D7, 1'b0);
        check("single_clk_en_count", clk_en_count - base, 1);

        // back-to-back: one pops immediately, so the fifth push fills the FIFO
        core_latency = 5;
        base = clk_en_count;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_angle = b2b_in[i];
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        check("b2b_full_in_ready", bus.in_ready, 1'b0);
        for (int i = 0; i < 5; i++) begin
            get_result($sformatf("b2b%0d", i), b2b_exp[i], 1'b0);
        end
        check("b2b_clk_en_count", clk_en_count - base, 5);

        // two-cycle done yields one result only
        core_latency = 8;
        core_hold = 2;
        base = clk_en_count;
        push_one("hold2", 32'h41600000);
        get_result("hold2", 32'h1B3A0000, 1'b0);
        repeat (30) @(negedge clk);
        check("hold2_no_extra_valid", bus.out_valid, 1'b0);
        check("hold2_clk_en_count", clk_en_count - base, 1);
        check("hold2_busy", busy, 1'b0);

        // output stall with two queued jobs
        core_hold = 1;
        base = clk_en_count;
        push_one("stall_a", 32'h40C00000);
        push_one("stall_b", 32'h40E00000);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        stall_err = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.out_result !== 32'h1A9A0000) stall_err++;
        end
        check("stall_stable", stall_err, 0);
        check("stall_clk_en_count", clk_en_count - base, 1);
        get_result("stall0", 32'h1A9A0000, 1'b0);
        get_result("stall1", 32'h1ABA0000, 1'b0);

        // timeout: issue to visible out_valid is 65 negedges (64 WAIT cycles)
        core_never = 1'b1;
        push_one("tmo", 32'h41000000);
        n = 0;
        while (!bus.cordic_clk_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("tmo_issue_seen", bus.cordic_clk_en, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("tmo_latency", n, 65);
        core_never = 1'b0;
        push_one("tmo_next", 32'h41100000);
        get_result("tmo", 32'h0, 1'b1);
        get_result("tmo_next", 32'h1B4A0000, 1'b0);

        // asynchronous reset in the middle of a job with three queued
        core_latency = 30;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_angle = 32'h41200000 + (i << 20);
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_angle", bus.cordic_angle, 32'h0);
        check("arst_clk_en", bus.cordic_clk_en, 1'b0);
        check("arst_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        base = clk_en_count;
        repeat (60) @(negedge clk);
        check("arst_no_issue", clk_en_count - base, 0);
        check("arst_stale_done_ignored", bus.out_valid, 1'b0);
        check("arst_idle_busy", busy, 1'b0);
        core_latency = 5;
        push_one("arst_new", 32'h3F060A92);
        get_result("arst_new", 32'h3F5DB3D7, 1'b0);

        check("angle_stable", angle_changes, 0);
        check("no_overlap", overlap_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
